// File: rtl/scan_sequencer.sv
// scan_sequencer: ROI-driven switch/read mux sequencer that issues one-cycle conversion strobes to adc_read.
// Define SCAN_SETTLE_EN to add SETTLE_CYC settle cycles after every switch-wire change.
module scan_sequencer #(
  parameter int SW_WIRE_CNT = 16,
  parameter int RD_WIRE_CNT = 16,
  parameter int TQUIET      = 4,
  parameter int TSERIAL     = 16,
  parameter int SETTLE_CYC  = 3,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           mode_cont,
  input  logic                           stop,
  input  logic [$clog2(SW_WIRE_CNT):0]   sw_first,
  input  logic [$clog2(SW_WIRE_CNT):0]   sw_last,
  input  logic [$clog2(RD_WIRE_CNT):0]   rd_first,
  input  logic [$clog2(RD_WIRE_CNT):0]   rd_last,
  output logic [$clog2(SW_WIRE_CNT):0]   sw_mux_sel,
  output logic [$clog2(RD_WIRE_CNT):0]   rd_mux_sel,
  output logic                           pulse_rd,
  output logic                           pulse_sw,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           cfg_err,
  output logic [FRAME_CNT_W-1:0]         frame_cnt
);

  localparam int SW_W     = $clog2(SW_WIRE_CNT) + 1;
  localparam int RD_W     = $clog2(RD_WIRE_CNT) + 1;
  localparam int SLOT_LEN = TQUIET + TSERIAL;
  localparam int SLOT_W   = $clog2(SLOT_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    CONVERT
  } state_t;

`ifdef SCAN_SETTLE_EN
  localparam int     STL_W     = $clog2(SETTLE_CYC + 1);
  localparam state_t ROW_ENTRY = SETTLE;
  logic [STL_W-1:0]  settle_cnt;
`else
  localparam state_t ROW_ENTRY = CONVERT;
`endif

  state_t            state, state_nxt;
  logic [SW_W-1:0]   sw_sel, sw_first_q, sw_last_q;
  logic [RD_W-1:0]   rd_sel, rd_first_q, rd_last_q;
  logic [SLOT_W-1:0] slot_cnt;
  logic              cont_q;
  logic              stop_pend;
  logic              cfg_err_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic start_ok, accept, slot_end, row_end, frame_end, restart;

  assign start_ok  = !((sw_first > sw_last) || (sw_last >= SW_W'(SW_WIRE_CNT)) ||
                       (rd_first > rd_last) || (rd_last >= RD_W'(RD_WIRE_CNT)));
  assign accept    = (state == IDLE) && start && start_ok;
  assign slot_end  = (state == CONVERT) && (slot_cnt == SLOT_W'(SLOT_LEN - 1));
  assign row_end   = slot_end && (rd_sel == rd_last_q);
  assign frame_end = row_end && (sw_sel == sw_last_q);
  // A stop arriving on the frame_done cycle itself still ends the run.
  assign restart   = frame_end && cont_q && !(stop_pend || stop);

  assign busy       = (state != IDLE);
  assign pulse_rd   = (state == CONVERT) && (slot_cnt == '0);
  assign pulse_sw   = (state == LAUNCH) || (row_end && !frame_end) || restart;
  assign frame_done = frame_end;
  assign sw_mux_sel = sw_sel;
  assign rd_mux_sel = rd_sel;
  assign cfg_err    = cfg_err_q;
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = ROW_ENTRY;
`ifdef SCAN_SETTLE_EN
      SETTLE:  if (settle_cnt == STL_W'(SETTLE_CYC - 1)) state_nxt = CONVERT;
`endif
      CONVERT: begin
        if (row_end) begin
          if (frame_end && !restart) state_nxt = IDLE;
          else                       state_nxt = ROW_ENTRY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Selects, slot timing, ROI latch and frame bookkeeping; selects hold in IDLE.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sw_sel      <= '0;
      rd_sel      <= '0;
      sw_first_q  <= '0;
      sw_last_q   <= '0;
      rd_first_q  <= '0;
      rd_last_q   <= '0;
      slot_cnt    <= '0;
      cont_q      <= 1'b0;
      stop_pend   <= 1'b0;
      cfg_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      cfg_err_q <= (state == IDLE) && start && !start_ok;

      if (accept) begin
        sw_first_q <= sw_first;
        sw_last_q  <= sw_last;
        rd_first_q <= rd_first;
        rd_last_q  <= rd_last;
        cont_q     <= mode_cont;
        sw_sel     <= sw_first;
        rd_sel     <= rd_first;
      end

      if (state == CONVERT && !slot_end) slot_cnt <= slot_cnt + SLOT_W'(1);
      else                               slot_cnt <= '0;

      if (slot_end) begin
        if (!row_end) begin
          rd_sel <= rd_sel + RD_W'(1);
        end else if (!frame_end) begin
          sw_sel <= sw_sel + SW_W'(1);
          rd_sel <= rd_first_q;
        end else if (restart) begin
          sw_sel <= sw_first_q;
          rd_sel <= rd_first_q;
        end
      end

      if (frame_end) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);

      if (accept || (frame_end && !restart)) stop_pend <= 1'b0;
      else if (busy && stop)                 stop_pend <= 1'b1;
    end
  end

`ifdef SCAN_SETTLE_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                 settle_cnt <= '0;
    else if (state == SETTLE)   settle_cnt <= settle_cnt + STL_W'(1);
    else                        settle_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed and random scans checked every cycle against a frame-position reference model.
module tb_scan_sequencer;

  localparam int FCW  = 2;
  localparam int SLOT = 20;
  localparam int NW   = 16;
`ifdef SCAN_SETTLE_EN
  localparam int SET_LEN = 3;
`else
  localparam int SET_LEN = 0;
`endif

  logic       clk_in = 1'b0;
  logic       rst_n, start, mode_cont, stop;
  logic [4:0] sw_first, sw_last, rd_first, rd_last;
  logic [4:0] sw_mux_sel, rd_mux_sel;
  logic       pulse_rd, pulse_sw, busy, frame_done, cfg_err;
  logic [FCW-1:0] frame_cnt;

  scan_sequencer #(.FRAME_CNT_W(FCW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .mode_cont(mode_cont), .stop(stop),
    .sw_first(sw_first), .sw_last(sw_last), .rd_first(rd_first), .rd_last(rd_last),
    .sw_mux_sel(sw_mux_sel), .rd_mux_sel(rd_mux_sel), .pulse_rd(pulse_rd),
    .pulse_sw(pulse_sw), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_in = ~clk_in;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Reference model: position k since launch, decoded arithmetically into row/column/slot phase.
  int m_busy, m_k, m_swf, m_swl, m_rdf, m_rdl, m_cont, m_pend, m_fcnt, m_cfg, m_sw_hold, m_rd_hold;
  int e_busy, e_sw, e_rd, e_prd, e_psw, e_fd, e_cfg, e_fcnt;
  int cyc, cnt_rd, cnt_sw, cnt_fd, start_cyc, fd_cyc;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compare_count++;
    if (actual != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic int roi_valid(input int sf, input int sl, input int rf, input int rl);
    return !(sf > sl || sl >= NW || rf > rl || rl >= NW);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_swf = 0; m_swl = 0; m_rdf = 0; m_rdl = 0;
    m_cont = 0; m_pend = 0; m_fcnt = 0; m_cfg = 0; m_sw_hold = 0; m_rd_hold = 0;
  endtask

  task automatic model_outputs();
    int sw_span, rd_span, r_len, f_len, p, row, q, s, go_on;
    e_prd = 0; e_psw = 0; e_fd = 0;
    e_cfg = m_cfg; e_fcnt = m_fcnt % (1 << FCW);
    e_busy = m_busy;
    e_sw = m_sw_hold; e_rd = m_rd_hold;
    if (m_busy != 0 && m_k == 0) begin
      e_sw = m_swf; e_rd = m_rdf; e_psw = 1;
    end else if (m_busy != 0) begin
      sw_span = m_swl - m_swf + 1;
      rd_span = m_rdl - m_rdf + 1;
      r_len   = SET_LEN + rd_span * SLOT;
      f_len   = sw_span * r_len;
      p   = (m_k - 1) % f_len;
      row = p / r_len;
      q   = p % r_len;
      e_sw = m_swf + row;
      if (q < SET_LEN) e_rd = m_rdf;
      else begin
        s = q - SET_LEN;
        e_rd  = m_rdf + s / SLOT;
        e_prd = ((s % SLOT) == 0);
      end
      e_fd  = (p == f_len - 1);
      go_on = m_cont != 0 && !(m_pend != 0 || stop);
      e_psw = (q == r_len - 1) && (!e_fd || go_on);
    end
  endtask

  task automatic model_advance();
    if (m_busy == 0) begin
      m_cfg = start && !roi_valid(sw_first, sw_last, rd_first, rd_last);
      if (start && roi_valid(sw_first, sw_last, rd_first, rd_last)) begin
        m_busy = 1; m_k = 0; m_pend = 0; m_cont = mode_cont;
        m_swf = sw_first; m_swl = sw_last; m_rdf = rd_first; m_rdl = rd_last;
        m_sw_hold = sw_first; m_rd_hold = rd_first;
      end
    end else begin
      m_cfg = 0;
      m_sw_hold = e_sw; m_rd_hold = e_rd;
      if (e_fd != 0) begin
        m_fcnt++;
        if (m_cont != 0 && !(m_pend != 0 || stop)) m_k++;
        else begin m_busy = 0; m_pend = 0; end
      end else begin
        m_k++;
        if (stop) m_pend = 1;
      end
    end
  endtask

  // Each step: compare every output with the model under the current inputs, then clock once.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      #1;
      model_outputs();
      checkOutput("busy", busy, e_busy);
      checkOutput("sw_mux_sel", sw_mux_sel, e_sw);
      checkOutput("rd_mux_sel", rd_mux_sel, e_rd);
      checkOutput("pulse_rd", pulse_rd, e_prd);
      checkOutput("pulse_sw", pulse_sw, e_psw);
      checkOutput("frame_done", frame_done, e_fd);
      checkOutput("cfg_err", cfg_err, e_cfg);
      checkOutput("frame_cnt", frame_cnt, e_fcnt);
      cnt_rd += pulse_rd; cnt_sw += pulse_sw; cnt_fd += frame_done;
      if (frame_done) fd_cyc = cyc;
      model_advance();
      @(negedge clk_in);
      cyc++;
    end
  endtask

  task automatic set_roi(input int sf, input int sl, input int rf, input int rl);
    sw_first = 5'(sf); sw_last = 5'(sl); rd_first = 5'(rf); rd_last = 5'(rl);
  endtask

  task automatic pulse_start(input int cont);
    mode_cont = cont[0];
    start = 1'b1;
    start_cyc = cyc;
    applyStimulus(1);
    start = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_rd = 0; cnt_sw = 0; cnt_fd = 0; fd_cyc = -1;
  endtask

  task automatic randomize_roi();
    int a, b;
    a = $urandom_range(0, 15);
    b = a + $urandom_range(0, 2);
    if ($urandom_range(0, 9) == 0 && b > a) begin sw_first = 5'(b); sw_last = 5'(a); end
    else begin sw_first = 5'(a); sw_last = 5'(b); end
    a = $urandom_range(0, 15);
    b = a + $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0 && b > a) begin rd_first = 5'(b); rd_last = 5'(a); end
    else begin rd_first = 5'(a); rd_last = 5'(b); end
  endtask

  initial begin
    start = 0; stop = 0; mode_cont = 0; cyc = 0;
    set_roi(0, 15, 0, 15);
    clear_counts();
    model_reset();
    rst_n = 1'b0;
    #23;
    @(negedge clk_in);
    rst_n = 1'b1;
    applyStimulus(3);

    // Full ROI, single frame
    clear_counts();
    pulse_start(0);
    applyStimulus(256 * SLOT + 16 * SET_LEN + 20);
    checkOutput("full_rd_pulses", cnt_rd, 256);
    checkOutput("full_frame_len", fd_cyc - start_cyc - 1, 256 * SLOT + 16 * SET_LEN);
    checkOutput("full_sw_pulses", cnt_sw, 16);
    checkOutput("full_frame_cnt", frame_cnt, 1);

    // Small ROI with row change
    clear_counts();
    set_roi(2, 3, 5, 7);
    pulse_start(0);
    applyStimulus(6 * SLOT + 2 * SET_LEN + 10);
    checkOutput("roi_rd_pulses", cnt_rd, 6);
    checkOutput("roi_sw_pulses", cnt_sw, 2);
    checkOutput("roi_frame_len", fd_cyc - start_cyc - 1, 6 * SLOT + 2 * SET_LEN);

    // Continuous full ROI, stop in the middle of frame 2
    clear_counts();
    set_roi(0, 15, 0, 15);
    pulse_start(1);
    applyStimulus(256 * SLOT + 16 * SET_LEN + 700);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(256 * SLOT + 200);
    checkOutput("stop_frames", cnt_fd, 2);
    checkOutput("stop_idle", busy, 0);

    // Rejected starts
    clear_counts();
    set_roi(0, 15, 9, 4);
    pulse_start(0);
    applyStimulus(5);
    set_roi(0, 16, 0, 15);
    pulse_start(1);
    applyStimulus(5);
    checkOutput("reject_rd_pulses", cnt_rd, 0);
    checkOutput("reject_sw_pulses", cnt_sw, 0);

    // Async reset in the middle of a slot of a continuous run
    set_roi(0, 15, 0, 15);
    pulse_start(1);
    applyStimulus(337);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pulse_rd", pulse_rd, 0);
    checkOutput("rst_sw_sel", sw_mux_sel, 0);
    checkOutput("rst_rd_sel", rd_mux_sel, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    clear_counts();
    applyStimulus(60);
    checkOutput("post_rst_pulses", cnt_rd + cnt_sw, 0);

    // Single-wire ROI, continuous: one slot per frame, frame counter wraps
    clear_counts();
    set_roi(7, 7, 7, 7);
    pulse_start(1);
    applyStimulus(1 + 9 * (SLOT + SET_LEN));
    checkOutput("single_frames", cnt_fd, 9);
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(SLOT + SET_LEN + 5);

    // Random traffic, including live-input changes and start/stop while busy
    for (int i = 0; i < 20000; i++) begin
      start = ($urandom_range(0, 99) < 4);
      stop  = ($urandom_range(0, 999) < 5);
      mode_cont = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < 3) randomize_roi();
      applyStimulus(1);
    end
    start = 0;
    stop = 1'b1;
    applyStimulus(1);
    stop = 1'b0;
    applyStimulus(400);
    checkOutput("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
